simplez_core: RTL and testbench

//  Parametrised Simplez CPU core: full four-state sequencer (I0/I1/O0/O1) executing
//  all 8 Simplez opcodes against an external memory port with wait-state handshake.

---
 rtl/simplez_mem_if.sv | 23 ++
 rtl/simplez_core.sv | 163 ++++++++++++++++
 tb/tb_simplez_core.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simplez_mem_if.sv
// Memory port of the Simplez core: single-outstanding read/write access with a
// ready handshake that inserts wait states.
interface simplez_mem_if #(
   parameter int ADDRW = 9,
   parameter int DATAW = 12
) ();
   logic [ADDRW-1:0] mem_addr;
   logic             mem_rd;
   logic             mem_wr;
   logic [DATAW-1:0] mem_wdata;
   logic [DATAW-1:0] mem_rdata;
   logic             mem_ready;

   modport master (
      output mem_addr, mem_rd, mem_wr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_addr, mem_rd, mem_wr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/simplez_core.sv
// Simplez CPU core: four-phase sequencer running the eight Simplez opcodes over a
// wait-stated memory port, with single-step gating of instruction fetch.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_I0   | fetch RI from mem[CP] (gated by step mode), CP++
//   ST_I1   | decode; execute CLR/DEC/BR/BZ, latch RA for memory ops
//   ST_O0   | operand access at RA: ST writes AC, LD/ADD read
//   ST_O1   | termination of a memory-operand instruction
//   ST_HALT | terminal; only reset leaves
module simplez_core #(
   parameter int              ADDRW    = 9,
   parameter int              DATAW    = ADDRW + 3,
   parameter logic [ADDRW-1:0] RESET_CP = '0
) (
   input  logic             clk,
   input  logic             rstn,
   simplez_mem_if.master    mem,
   input  logic             step_en,
   input  logic             step,
   output logic             halted,
   output logic [2:0]       co,
   output logic [ADDRW-1:0] cp,
   output logic [DATAW-1:0] ac
);
   typedef enum logic [2:0] {
      ST_I0   = 3'd0,
      ST_I1   = 3'd1,
      ST_O0   = 3'd2,
      ST_O1   = 3'd3,
      ST_HALT = 3'd4
   } state_t;

   localparam logic [2:0] OP_ST   = 3'd0;
   localparam logic [2:0] OP_LD   = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_BR   = 3'd3;
   localparam logic [2:0] OP_BZ   = 3'd4;
   localparam logic [2:0] OP_CLR  = 3'd5;
   localparam logic [2:0] OP_DEC  = 3'd6;
   localparam logic [2:0] OP_HALT = 3'd7;

   state_t           state_q, state_d;
   logic [ADDRW-1:0] cp_q, cp_d;
   logic [ADDRW-1:0] ra_q, ra_d;
   logic [DATAW-1:0] ri_q, ri_d;
   logic [DATAW-1:0] ac_q, ac_d;
   logic             step_pend_q, step_pend_d;

   logic [2:0]       op;
   logic [ADDRW-1:0] cd;
   logic             fetch_en;
   logic             opnd_rd;
   logic             opnd_wr;

   always_comb begin
      op       = ri_q[DATAW-1:ADDRW];
      cd       = ri_q[ADDRW-1:0];
      fetch_en = (state_q == ST_I0) && (!step_en || step_pend_q);
      opnd_rd  = (state_q == ST_O0) && ((op == OP_LD) || (op == OP_ADD));
      opnd_wr  = (state_q == ST_O0) && (op == OP_ST);

      state_d     = state_q;
      cp_d        = cp_q;
      ra_d        = ra_q;
      ri_d        = ri_q;
      ac_d        = ac_q;
      step_pend_d = step_pend_q;

      if (step && (state_q != ST_HALT)) begin
         step_pend_d = 1'b1;
      end

      case (state_q)
         ST_I0: begin
            // a step pulse landing on the completing fetch edge is absorbed here
            if (fetch_en && mem.mem_ready) begin
               ri_d        = mem.mem_rdata;
               cp_d        = cp_q + ADDRW'(1);
               step_pend_d = 1'b0;
               state_d     = ST_I1;
            end
         end
         ST_I1: begin
            case (op)
               OP_CLR: begin
                  ac_d    = '0;
                  state_d = ST_I0;
               end
               OP_DEC: begin
                  ac_d    = ac_q - DATAW'(1);
                  state_d = ST_I0;
               end
               OP_BR: begin
                  cp_d    = cd;
                  state_d = ST_I0;
               end
               OP_BZ: begin
                  if (ac_q == '0) begin
                     cp_d = cd;
                  end
                  state_d = ST_I0;
               end
               OP_HALT: begin
                  state_d = ST_HALT;
               end
               default: begin
                  ra_d    = cd;
                  state_d = ST_O0;
               end
            endcase
         end
         ST_O0: begin
            if (mem.mem_ready) begin
               if (op == OP_LD) begin
                  ac_d = mem.mem_rdata;
               end else if (op == OP_ADD) begin
                  ac_d = ac_q + mem.mem_rdata;
               end
               state_d = ST_O1;
            end
         end
         ST_O1: begin
            state_d = ST_I0;
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_I0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_I0;
         cp_q        <= RESET_CP;
         ra_q        <= '0;
         ri_q        <= '0;
         ac_q        <= '0;
         step_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cp_q        <= cp_d;
         ra_q        <= ra_d;
         ri_q        <= ri_d;
         ac_q        <= ac_d;
         step_pend_q <= step_pend_d;
      end
   end

   // Reset state is I0, which would otherwise request a fetch while rstn is low.
   assign mem.mem_rd    = rstn && (fetch_en || opnd_rd);
   assign mem.mem_wr    = rstn && opnd_wr;
   assign mem.mem_addr  = (state_q == ST_O0) ? ra_q : cp_q;
   assign mem.mem_wdata = ac_q;

   assign halted = (state_q == ST_HALT);
   assign co     = op;
   assign cp     = cp_q;
   assign ac     = ac_q;
endmodule

// File: tb/tb_simplez_core.sv
// Directed bench for simplez_core: table of small programs plus hand-written
// sequences for wait states, single-step, mid-access reset and narrow-width wrap.
module tb_simplez_core;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic rstn1 = 1'b0;
   logic step_en = 1'b0;
   logic step = 1'b0;

   always #5 clk = ~clk;

   logic        halted, halted1;
   logic [2:0]  co, co1;
   logic [8:0]  cp;
   logic [11:0] ac;
   logic [3:0]  cp1;
   logic [6:0]  ac1;

   simplez_mem_if #(.ADDRW(9), .DATAW(12)) m0 ();
   simplez_mem_if #(.ADDRW(4), .DATAW(7))  m1 ();

   simplez_core #(.ADDRW(9), .DATAW(12), .RESET_CP(9'd0)) dut0 (
      .clk(clk), .rstn(rstn), .mem(m0), .step_en(step_en), .step(step),
      .halted(halted), .co(co), .cp(cp), .ac(ac)
   );

   simplez_core #(.ADDRW(4), .DATAW(7), .RESET_CP(4'd2)) dut1 (
      .clk(clk), .rstn(rstn1), .mem(m1), .step_en(1'b0), .step(1'b0),
      .halted(halted1), .co(co1), .cp(cp1), .ac(ac1)
   );

   // memory models and loader
   logic [11:0] mem0 [512];
   logic [6:0]  mem1 [16];
   logic        ld_clr = 1'b0, ld_we0 = 1'b0, ld_we1 = 1'b0;
   logic [8:0]  ld_addr = '0;
   logic [11:0] ld_data = '0;
   int          nwait = 0;
   int          wcnt = 0;

   assign m0.mem_rdata = mem0[m0.mem_addr];
   assign m0.mem_ready = (wcnt >= nwait);
   assign m1.mem_rdata = mem1[m1.mem_addr];
   assign m1.mem_ready = 1'b1;

   always @(posedge clk) begin
      if (ld_clr) begin
         for (int i = 0; i < 512; i++) mem0[i] <= '0;
      end else if (ld_we0) begin
         mem0[ld_addr] <= ld_data;
      end else if (m0.mem_wr && m0.mem_ready) begin
         mem0[m0.mem_addr] <= m0.mem_wdata;
      end
      if (!(m0.mem_rd || m0.mem_wr) || m0.mem_ready) wcnt <= 0;
      else wcnt <= wcnt + 1;
   end

   always @(posedge clk) begin
      if (ld_clr) begin
         for (int i = 0; i < 16; i++) mem1[i] <= '0;
      end else if (ld_we1) begin
         mem1[ld_addr[3:0]] <= ld_data[6:0];
      end else if (m1.mem_wr && m1.mem_ready) begin
         mem1[m1.mem_addr] <= m1.mem_wdata;
      end
   end

   // bus stability while waiting, and read-request counter
   logic        prev_wait = 1'b0;
   logic [10:0] prev_bus = '0;
   int          viol = 0;
   int          rd_cnt = 0;

   always @(posedge clk) begin
      if (rstn && prev_wait && ({m0.mem_rd, m0.mem_wr, m0.mem_addr} != prev_bus))
         viol <= viol + 1;
      prev_wait <= rstn && (m0.mem_rd || m0.mem_wr) && !m0.mem_ready;
      prev_bus  <= {m0.mem_rd, m0.mem_wr, m0.mem_addr};
      if (m0.mem_rd) rd_cnt <= rd_cnt + 1;
   end

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [11:0] p [8];
      logic [11:0] d10;
      logic [11:0] d11;
      int          nw;
      logic [11:0] eac;
      logic [8:0]  ecp;
      int          ecyc;
      logic [11:0] em12;
   } vec_t;

   function automatic vec_t mk(input logic [11:0] p0, p1, p2, p3, p4, p5, p6, p7,
                               input logic [11:0] d10, d11, input int nw,
                               input logic [11:0] eac, input logic [8:0] ecp,
                               input int ecyc, input logic [11:0] em12);
      vec_t v;
      v.p    = '{p0, p1, p2, p3, p4, p5, p6, p7};
      v.d10  = d10;
      v.d11  = d11;
      v.nw   = nw;
      v.eac  = eac;
      v.ecp  = ecp;
      v.ecyc = ecyc;
      v.em12 = em12;
      return v;
   endfunction

   task automatic poke0(input logic [8:0] a, input logic [11:0] d);
      ld_we0 = 1'b1; ld_addr = a; ld_data = d;
      @(posedge clk); #1;
      ld_we0 = 1'b0;
   endtask

   task automatic poke1(input logic [3:0] a, input logic [6:0] d);
      ld_we1 = 1'b1; ld_addr = {5'd0, a}; ld_data = {5'd0, d};
      @(posedge clk); #1;
      ld_we1 = 1'b0;
   endtask

   task automatic clear_mem();
      ld_clr = 1'b1;
      @(posedge clk); #1;
      ld_clr = 1'b0;
   endtask

   task automatic load0(input vec_t v);
      clear_mem();
      for (int i = 0; i < 8; i++) poke0(9'(i), v.p[i]);
      poke0(9'd10, v.d10);
      poke0(9'd11, v.d11);
   endtask

   task automatic run0(input int limit, output int cyc);
      cyc = 0;
      while (!halted && cyc < limit) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   // opcode words for ADDRW=9: {co, cd}
   localparam logic [11:0] I_HALT = 12'hE00;
   localparam logic [11:0] I_CLR  = 12'hA00;
   localparam logic [11:0] I_DEC  = 12'hC00;

   vec_t vecs [7];
   int   cyc;
   int   r0;
   int   k;

   initial begin
      vecs[0] = mk(12'h20A, 12'h40B, 12'h00C, I_HALT, 0, 0, 0, 0,
                   12'd5, 12'd7, 0, 12'd12, 9'd4, 14, 12'd12);
      vecs[1] = mk(12'h20A, 12'h40B, 12'h00C, I_HALT, 0, 0, 0, 0,
                   12'd5, 12'd7, 3, 12'd12, 9'd4, 35, 12'd12);
      vecs[2] = mk(I_CLR, I_DEC, 12'h805, I_HALT, 0, I_HALT, 0, 0,
                   12'd0, 12'd0, 0, 12'hFFF, 9'd4, 8, 12'd0);
      vecs[3] = mk(I_CLR, 12'h805, I_HALT, I_HALT, 0, I_HALT, 0, 0,
                   12'd0, 12'd0, 0, 12'd0, 9'd6, 6, 12'd0);
      vecs[4] = mk(12'h20A, 12'h40B, 12'h00C, I_HALT, 0, 0, 0, 0,
                   12'hFFF, 12'd2, 0, 12'd1, 9'd4, 14, 12'd1);
      vecs[5] = mk(12'h606, 0, 0, 0, 0, 0, I_DEC, I_HALT,
                   12'd0, 12'd0, 1, 12'hFFF, 9'd8, 9, 12'd0);
      vecs[6] = mk(12'h20A, 12'h805, I_HALT, 0, 0, I_HALT, 0, 0,
                   12'd3, 12'd0, 0, 12'd3, 9'd3, 8, 12'd0);

      // reset state
      @(posedge clk); #1;
      chk("rst_mem_rd", 32'(m0.mem_rd), 32'd0);
      chk("rst_mem_wr", 32'(m0.mem_wr), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_co", 32'(co), 32'd0);
      chk("rst_cp", 32'(cp), 32'd0);
      chk("rst_ac", 32'(ac), 32'd0);

      // program table, free run
      for (int i = 0; i < 7; i++) begin
         rstn = 1'b0;
         step_en = 1'b0;
         load0(vecs[i]);
         nwait = vecs[i].nw;
         rstn = 1'b1;
         run0(250, cyc);
         chk($sformatf("v%0d_halted", i), 32'(halted), 32'd1);
         chk($sformatf("v%0d_ac", i), 32'(ac), 32'(vecs[i].eac));
         chk($sformatf("v%0d_cp", i), 32'(cp), 32'(vecs[i].ecp));
         chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].ecyc));
         chk($sformatf("v%0d_mem12", i), 32'(mem0[12]), 32'(vecs[i].em12));
      end
      chk("wait_bus_stable", 32'(viol), 32'd0);

      // single-step: LD 10; LD 11; DEC; HALT
      rstn = 1'b0;
      load0(mk(12'h20A, 12'h20B, I_DEC, I_HALT, 0, 0, 0, 0,
               12'd5, 12'd9, 0, 0, 0, 0, 0));
      nwait = 0;
      step_en = 1'b1;
      rstn = 1'b1;
      r0 = rd_cnt;
      repeat (10) begin @(posedge clk); #1; end
      chk("step_idle_rd", 32'(rd_cnt - r0), 32'd0);
      chk("step_idle_cp", 32'(cp), 32'd0);

      step = 1'b1; @(posedge clk); #1; step = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      chk("step1_ac", 32'(ac), 32'd5);
      chk("step1_cp", 32'(cp), 32'd1);
      chk("step1_rd", 32'(m0.mem_rd), 32'd0);

      nwait = 3;
      step = 1'b1; @(posedge clk); #1; step = 1'b0;
      k = 0;
      while (!(m0.mem_rd && m0.mem_addr == 9'd11) && k < 30) begin
         @(posedge clk); #1;
         k++;
      end
      chk("step2_o0_seen", 32'(m0.mem_rd && m0.mem_addr == 9'd11), 32'd1);
      step = 1'b1; @(posedge clk); #1; step = 1'b0;
      @(posedge clk); #1;
      step = 1'b1; @(posedge clk); #1; step = 1'b0;
      repeat (40) begin @(posedge clk); #1; end
      chk("step2_ac", 32'(ac), 32'd8);
      chk("step2_cp", 32'(cp), 32'd3);
      chk("step2_rd", 32'(m0.mem_rd), 32'd0);
      chk("step2_halted", 32'(halted), 32'd0);

      // reset while ST waits: DEC; ST 12; HALT
      rstn = 1'b0;
      step_en = 1'b0;
      load0(mk(I_DEC, 12'h00C, I_HALT, 0, 0, 0, 0, 0,
               12'd0, 12'd0, 0, 0, 0, 0, 0));
      poke0(9'd12, 12'h123);
      nwait = 20;
      rstn = 1'b1;
      k = 0;
      while (!m0.mem_wr && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      chk("rst_mid_wr_seen", 32'(m0.mem_wr), 32'd1);
      #2 rstn = 1'b0;
      #1;
      chk("rst_mid_wr_drop", 32'(m0.mem_wr), 32'd0);
      chk("rst_mid_rd", 32'(m0.mem_rd), 32'd0);
      chk("rst_mid_ac", 32'(ac), 32'd0);
      @(posedge clk); #1;
      chk("rst_mid_mem12", 32'(mem0[12]), 32'h123);
      nwait = 0;
      rstn = 1'b1;
      #1;
      chk("rst_refetch_rd", 32'(m0.mem_rd), 32'd1);
      chk("rst_refetch_addr", 32'(m0.mem_addr), 32'd0);
      run0(100, cyc);
      chk("rst_rerun_halted", 32'(halted), 32'd1);
      chk("rst_rerun_cp", 32'(cp), 32'd3);
      chk("rst_rerun_mem12", 32'(mem0[12]), 32'hFFF);

      // narrow core, RESET_CP=2: LD 10; ADD 11; ST 12; BR 15; @15 CLR; @0 HALT
      clear_mem();
      poke1(4'd0, 7'h70);
      poke1(4'd2, 7'h1A);
      poke1(4'd3, 7'h2B);
      poke1(4'd4, 7'h0C);
      poke1(4'd5, 7'h3F);
      poke1(4'd15, 7'h50);
      poke1(4'd10, 7'h7F);
      poke1(4'd11, 7'h01);
      poke1(4'd12, 7'h55);
      rstn1 = 1'b1;
      cyc = 0;
      while (!halted1 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("n_halted", 32'(halted1), 32'd1);
      chk("n_cycles", 32'(cyc), 32'd18);
      chk("n_cp_wrap", 32'(cp1), 32'd1);
      chk("n_ac", 32'(ac1), 32'd0);
      chk("n_add_ovf", 32'(mem1[12]), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
